// File: rtl/arith_share_sched.sv
// Round-robin scheduler sharing one 3-operand arithmetic/reduction unit between NUM_REQ requesters.
// One op in flight at a time: IDLE (grant) -> EXEC (1 or MUL_CYCLES cycles) -> RESP (hold until accepted).
module arith_share_sched #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 128,
    parameter int MUL_CYCLES = 4,
    parameter int ID_W       = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [NUM_REQ*3-1:0]     i_req_op,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_c,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [ID_W-1:0]          o_rsp_id,
    output logic [3*WIDTH-1:0]       o_rsp_data,
    output logic                     o_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

    logic [1:0]           r_state;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_op;
    logic [WIDTH-1:0]     r_a, r_b, r_c;
    logic [ID_W-1:0]      r_rsp_id;
    logic [3*WIDTH-1:0]   r_rsp_data;

    logic                 w_hit_hi, w_hit_any;
    logic [ID_W-1:0]      w_gnt_hi, w_gnt_lo, w_gnt, w_next_ptr;
    logic                 w_accept, w_is_mul;
    logic [2:0]           w_op;
    logic [NUM_REQ-1:0]   w_ready;
    logic [3*WIDTH-1:0]   w_result;
    logic [3*WIDTH-1:0]   w_ax, w_bx, w_cx, w_as, w_bs, w_cs;

    // Rotating priority: lowest valid index at or above rr_ptr, else lowest valid index overall.
    always_comb begin
        w_hit_hi  = 1'b0;
        w_hit_any = 1'b0;
        w_gnt_hi  = '0;
        w_gnt_lo  = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (i_req_valid[j]) begin
                if (!w_hit_any) begin
                    w_hit_any = 1'b1;
                    w_gnt_lo  = ID_W'(j);
                end
                if (!w_hit_hi && (ID_W'(j) >= r_rr_ptr)) begin
                    w_hit_hi = 1'b1;
                    w_gnt_hi = ID_W'(j);
                end
            end
        end
        w_gnt = w_hit_hi ? w_gnt_hi : w_gnt_lo;
    end

    assign w_accept   = (r_state == S_IDLE) && w_hit_any;
    assign w_op       = i_req_op[3*w_gnt +: 3];
    assign w_is_mul   = (w_op == 3'd2) || (w_op == 3'd3);
    assign w_next_ptr = (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + ID_W'(1);

    always_comb begin
        w_ready = '0;
        if (rst_n && w_accept) begin
            w_ready[w_gnt] = 1'b1;
        end
    end

    assign w_ax = {{(2*WIDTH){1'b0}}, r_a};
    assign w_bx = {{(2*WIDTH){1'b0}}, r_b};
    assign w_cx = {{(2*WIDTH){1'b0}}, r_c};
    assign w_as = {{(2*WIDTH){r_a[WIDTH-1]}}, r_a};
    assign w_bs = {{(2*WIDTH){r_b[WIDTH-1]}}, r_b};
    assign w_cs = {{(2*WIDTH){r_c[WIDTH-1]}}, r_c};

    always_comb begin
        w_result = '0;
        case (r_op)
            3'd0: w_result[WIDTH+1:0] = {2'b00, r_a} + {2'b00, r_b} + {2'b00, r_c};
            3'd1: w_result[WIDTH+1:0] = {2'b00, r_a} - {2'b00, r_b} - {2'b00, r_c};
            3'd2: w_result = w_ax * w_bx * w_cx;
            3'd3: w_result = w_as * w_bs * w_cs;
            3'd4: w_result[0] = |(r_a & r_b & r_c);
            3'd5: w_result[0] = ^(r_a & r_b & r_c);
            3'd6: w_result[0] = (r_a == r_b);
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= w_op;
                        r_a      <= i_req_a[WIDTH*w_gnt +: WIDTH];
                        r_b      <= i_req_b[WIDTH*w_gnt +: WIDTH];
                        r_c      <= i_req_c[WIDTH*w_gnt +: WIDTH];
                        r_rsp_id <= w_gnt;
                        r_rr_ptr <= w_next_ptr;
                        r_cnt    <= w_is_mul ? MUL_LAST : '0;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == '0) begin
                        r_rsp_data <= w_result;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready = w_ready;
    assign o_rsp_valid = (r_state == S_RESP);
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = r_rsp_data;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_arith_share_sched.sv
// Randomized bench for arith_share_sched: arbitration, latency, results and response
// holding are checked against a behavioural model of the scheduler and the arithmetic.
module tb_arith_share_sched;

    localparam int N   = 4;
    localparam int W   = 128;
    localparam int MC  = 4;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*3-1:0]     req_op;
    logic [N*W-1:0]     req_a, req_b, req_c;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [3*W-1:0]     rsp_data;
    logic               busy;

    int tests = 0;
    int fails = 0;
    int m_ptr = 0;
    int last_grant;

    logic [2:0]   m_op [N];
    logic [W-1:0] m_a  [N];
    logic [W-1:0] m_b  [N];
    logic [W-1:0] m_c  [N];

    arith_share_sched #(
        .NUM_REQ   (N),
        .WIDTH     (W),
        .MUL_CYCLES(MC),
        .ID_W      (IDW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_op   (req_op),
        .i_req_a    (req_a),
        .i_req_b    (req_b),
        .i_req_c    (req_c),
        .o_rsp_valid(rsp_valid),
        .i_rsp_ready(rsp_ready),
        .o_rsp_id   (rsp_id),
        .o_rsp_data (rsp_data),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [3*W-1:0] model_result(input logic [2:0] op, input logic [W-1:0] a,
                                                     input logic [W-1:0] b, input logic [W-1:0] c);
        logic [3*W-1:0] r;
        logic [W-1:0]   ma, mb, mc;
        logic           neg;
        r = '0;
        case (op)
            3'd0: r = 384'(a) + 384'(b) + 384'(c);
            3'd1: begin
                r = 384'(a) - 384'(b) - 384'(c);
                r[3*W-1:W+2] = '0;
            end
            3'd2: r = 384'(a) * 384'(b) * 384'(c);
            3'd3: begin
                neg = a[W-1] ^ b[W-1] ^ c[W-1];
                ma = a[W-1] ? (~a + 1'b1) : a;
                mb = b[W-1] ? (~b + 1'b1) : b;
                mc = c[W-1] ? (~c + 1'b1) : c;
                r = 384'(ma) * 384'(mb) * 384'(mc);
                if (neg) r = ~r + 1'b1;
            end
            3'd4: r = ((a & b & c) != '0) ? 384'd1 : 384'd0;
            3'd5: r = ($countones(a & b & c) % 2 == 1) ? 384'd1 : 384'd0;
            3'd6: r = (a == b) ? 384'd1 : 384'd0;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int model_grant(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rand128();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0: return '1;
            1: return '0;
            2: return W'($urandom_range(0, 15));
            3: return {1'b1, 127'($urandom_range(0, 7))};
            default: return {$urandom, $urandom, $urandom, $urandom};
        endcase
    endfunction

    task automatic randomize_req(input int i);
        m_op[i] = 3'($urandom_range(0, 7));
        m_a[i]  = rand128();
        m_b[i]  = rand128();
        m_c[i]  = rand128();
        if (m_op[i] == 3'd6 && $urandom_range(0, 1) == 1) m_b[i] = m_a[i];
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] c);
        m_op[i] = op;
        m_a[i]  = a;
        m_b[i]  = b;
        m_c[i]  = c;
    endtask

    task automatic drive_operands();
        for (int i = 0; i < N; i++) begin
            req_op[3*i +: 3] = m_op[i];
            req_a[W*i +: W]  = m_a[i];
            req_b[W*i +: W]  = m_b[i];
            req_c[W*i +: W]  = m_c[i];
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    // One full transaction: grant, execute, optional backpressure, response handshake.
    task automatic do_round(input logic [N-1:0] vmask, input int hold);
        int g, k, j;
        logic [3*W-1:0] exp_d;
        logic [N-1:0]   exp_rdy;
        @(negedge clk);
        drive_operands();
        req_valid = vmask;
        #1;
        g = model_grant(vmask, m_ptr);
        exp_rdy = '0;
        exp_rdy[g] = 1'b1;
        tests++;
        if (req_ready !== exp_rdy) begin
            fails++;
            $display("FAIL grant: req_ready=%b expected %b (valid=%b)", req_ready, exp_rdy, vmask);
        end
        last_grant = -1;
        for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) last_grant = i;
        exp_d = model_result(m_op[g], m_a[g], m_b[g], m_c[g]);
        k = (m_op[g] == 3'd2 || m_op[g] == 3'd3) ? MC : 1;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        m_ptr = (g + 1) % N;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_exec: busy=%b expected 1", busy);
        end
        j = 0;
        while (rsp_valid !== 1'b1 && j < 20) begin
            @(posedge clk);
            @(negedge clk);
            j++;
        end
        tests++;
        if (j != k) begin
            fails++;
            $display("FAIL latency: rsp_valid after %0d cycles expected %0d (op=%0d)", j, k, m_op[g]);
        end
        tests++;
        if (rsp_data !== exp_d) begin
            fails++;
            $display("FAIL data: op=%0d rsp_data=%h expected %h", m_op[g], rsp_data, exp_d);
        end
        tests++;
        if (rsp_id !== g[IDW-1:0]) begin
            fails++;
            $display("FAIL rsp_id: rsp_id=%0d expected %0d", rsp_id, g);
        end
        if (hold > 0) req_valid = vmask;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            tests++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== g[IDW-1:0] || req_ready !== '0) begin
                fails++;
                $display("FAIL hold: cycle %0d valid=%b id=%0d ready=%b data=%h expected valid=1 id=%0d ready=0 data=%h",
                         h, rsp_valid, rsp_id, req_ready, rsp_data, g, exp_d);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = '0;
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL release: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) randomize_req(i);
        drive_operands();
        repeat (3) @(negedge clk);
        req_valid = '1;
        #1;
        tests++;
        if (req_ready !== '0) begin fails++; $display("FAIL reset_ready: req_ready=%b expected 0", req_ready); end
        tests++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: %b expected 0", rsp_valid); end
        tests++;
        if (rsp_id !== '0) begin fails++; $display("FAIL reset_rsp_id: %0d expected 0", rsp_id); end
        tests++;
        if (rsp_data !== '0) begin fails++; $display("FAIL reset_rsp_data: %h expected 0", rsp_data); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: %b expected 0", busy); end
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_directed();
        logic [W-1:0] ones;
        ones = '1;
        apply_reset();
        set_req(0, 3'd0, ones, ones, ones);              do_round(4'b0001, 0);
        set_req(1, 3'd1, '0, W'(1), W'(1));              do_round(4'b0010, 0);
        set_req(2, 3'd3, ones, W'(2), W'(3));            do_round(4'b0100, 0);
        set_req(3, 3'd6, W'(5), W'(5), rand128());       do_round(4'b1000, 0);
        set_req(0, 3'd4, W'(1), W'(1), '0);              do_round(4'b0001, 0);
        set_req(1, 3'd7, rand128(), rand128(), rand128()); do_round(4'b0010, 0);
        set_req(2, 3'd2, ones, ones, ones);              do_round(4'b0100, 0);
        set_req(3, 3'd5, ones, ones, W'(7));             do_round(4'b1000, 0);
    endtask

    task automatic test_round_robin();
        int cnt [N];
        apply_reset();
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            randomize_req(i);
        end
        for (int r = 0; r < 5; r++) begin
            do_round(4'b1111, 0);
            tests++;
            if (last_grant != r % N) begin
                fails++;
                $display("FAIL rr_order: round %0d granted %0d expected %0d", r, last_grant, r % N);
            end
            if (r < N && last_grant >= 0) cnt[last_grant]++;
            if (last_grant >= 0) randomize_req(last_grant);
        end
        for (int i = 0; i < N; i++) begin
            tests++;
            if (cnt[i] != 1) begin
                fails++;
                $display("FAIL rr_fair: requester %0d got %0d grants in one round expected 1", i, cnt[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N; i++) randomize_req(i);
        do_round(4'b0110, 10);
        m_op[3] = 3'd2;
        do_round(4'b1001, 10);
    endtask

    task automatic test_reset_midop();
        apply_reset();
        randomize_req(2);
        m_op[2] = 3'd2;
        @(negedge clk);
        drive_operands();
        req_valid = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        @(posedge clk);
        #2;
        req_valid = 4'b1100;
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== '0 || rsp_id !== '0 || rsp_data !== '0) begin
            fails++;
            $display("FAIL midop_reset: busy=%b rsp_valid=%b ready=%b id=%0d data=%h expected all 0",
                     busy, rsp_valid, req_ready, rsp_id, rsp_data);
        end
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < MC + 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            tests++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL midop_no_rsp: cycle %0d rsp_valid=%b busy=%b expected 0 0", i, rsp_valid, busy);
            end
        end
        randomize_req(2);
        randomize_req(3);
        do_round(4'b1100, 0);
        do_round(4'b1000, 0);
    endtask

    task automatic test_random();
        logic [N-1:0] vm;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) randomize_req(i);
            vm = N'($urandom_range(1, (1 << N) - 1));
            do_round(vm, $urandom_range(0, 2));
        end
    endtask

    initial begin
        req_valid = '0;
        rsp_ready = 1'b0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        test_reset();
        test_directed();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
